vlc_tx_frame_gen: RTL and testbench

//  Parametrised VLC frame transmitter; successor to the fixed tx loop.

---
 rtl/vlc_tx_pkg.sv | 32 +++
 rtl/vlc_tx_symbol_mod.sv | 67 ++++++
 rtl/vlc_tx_frame_gen.sv | 181 ++++++++++++++++++
 tb/tb_vlc_tx_frame_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_tx_pkg.sv
// Shared encodings for the VLC frame transmitter: FSM states, framing bytes,
// modulation selectors and the chip-level helper used by the symbol modulator.
package vlc_tx_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_PAY  = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PRE  = ST_PRE,
        S_SFD  = ST_SFD,
        S_LEN  = ST_LEN,
        S_PAY  = ST_PAY,
        S_GAP  = ST_GAP
    } state_t;

    localparam logic [7:0] SFD_BYTE = 8'hA7;
    localparam logic [7:0] PRE_BYTE = 8'hAA;

    localparam logic MODE_OOK = 1'b0;
    localparam logic MODE_MAN = 1'b1;

    // Manchester inverts the bit in the second half; OOK repeats it.
    function automatic logic chip_val(input logic b, input logic mode, input logic half);
        return (mode == MODE_MAN && half) ? ~b : b;
    endfunction

endpackage

// File: rtl/vlc_tx_symbol_mod.sv
// Serialises one byte LSB first into OOK or Manchester chips on the DAC code,
// flagging the last clock of the byte so the caller can load the next one seamlessly.
module vlc_tx_symbol_mod
    import vlc_tx_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int CLK_DIV = 4,
    parameter int HI_LVL  = 1023,
    parameter int LO_LVL  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             stop,
    input  logic [7:0]       data,
    input  logic             mode,
    output logic [WIDTH-1:0] tx_out,
    output logic             byte_done
);

    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [HALF_W-1:0] half_cnt;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              mode_q;
    logic              running;
    logic              half_last;
    logic [3:0]        nxt;

    function automatic logic [WIDTH-1:0] chip_level(input logic c);
        return c ? WIDTH'(HI_LVL) : WIDTH'(LO_LVL);
    endfunction

    assign half_last = (half_cnt == HALF_W'(CLK_DIV - 1));
    assign byte_done = running && half_last && (bit_cnt == 4'd15);
    // bit_cnt indexes half-bits: [3:1] selects the data bit, [0] the half.
    assign nxt       = bit_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= WIDTH'(LO_LVL);
        end else if (load) begin
            running  <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= data;
            mode_q   <= mode;
            tx_out   <= chip_level(chip_val(data[0], mode, 1'b0));
        end else if (stop || !running) begin
            running  <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= WIDTH'(LO_LVL);
        end else if (half_last) begin
            half_cnt <= '0;
            bit_cnt  <= nxt;
            tx_out   <= chip_level(chip_val(shreg[nxt[3:1]], mode_q, nxt[0]));
        end else begin
            half_cnt <= half_cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/vlc_tx_frame_gen.sv
// VLC frame transmitter: preamble, SFD, length byte and RAM payload, followed by an
// idle gap; single-shot or continuous, OOK or Manchester, driving a DAC code.
module vlc_tx_frame_gen
    import vlc_tx_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int CLK_DIV   = 4,
    parameter int PRE_BYTES = 4,
    parameter int ADDR_W    = 6,
    parameter int GAP_CYC   = 1000,
    parameter int HI_LVL    = 1023,
    parameter int LO_LVL    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_loop,
    input  logic              i_mode,
    input  logic [ADDR_W:0]   i_len,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [7:0]        i_rd_data,
    output logic [WIDTH-1:0]  o_tx_out,
    output logic              o_clk,
    output logic              o_tx_sfd,
    output logic              o_tx_ind,
    output logic              o_busy
);

    localparam int MAX_LEN = 2 ** ADDR_W;
    localparam int LEN_W   = ADDR_W + 1;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_in;
    logic [LEN_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             mode_q;
    logic             loop_q;

    logic             byte_done;
    logic             sym_load;
    logic             sym_stop;
    logic             sym_mode;
    logic [7:0]       sym_data;

    logic             pre_last;
    logic             pay_last;
    logic             addr_more;
    logic             gap_last;
    logic             restart;
    logic             enter_gap;

    assign o_clk     = ~clk;
    assign len_in    = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
    assign pre_last  = (byte_cnt == LEN_W'(PRE_BYTES - 1));
    assign pay_last  = (byte_cnt == len_q - LEN_W'(1));
    // Advance the RAM address only while a further byte remains to be fetched.
    assign addr_more = (LEN_W'(o_rd_addr) + LEN_W'(1)) < len_q;
    assign gap_last  = (gap_cnt == GAP_W'(GAP_CYC - 1));
    // Continuing needs both the frame's latched loop flag and a still-asserted i_loop.
    assign restart   = (state == S_GAP) && gap_last && loop_q && i_loop;
    assign enter_gap = byte_done && (((state == S_LEN) && (len_q == '0)) ||
                                     ((state == S_PAY) && pay_last));

    always_comb begin
        sym_load = 1'b0;
        sym_stop = 1'b0;
        sym_data = PRE_BYTE;
        sym_mode = mode_q;
        case (state)
            S_IDLE: begin
                sym_load = i_start;
                sym_mode = i_mode;
            end
            S_PRE: begin
                sym_load = byte_done;
                sym_data = pre_last ? SFD_BYTE : PRE_BYTE;
            end
            S_SFD: begin
                sym_load = byte_done;
                sym_data = 8'(len_q);
            end
            S_LEN, S_PAY: begin
                sym_stop = enter_gap;
                sym_load = byte_done && !enter_gap;
                sym_data = i_rd_data;
            end
            S_GAP: begin
                sym_load = restart;
                sym_mode = i_mode;
            end
            default: ;
        endcase
    end

    vlc_tx_symbol_mod #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV),
        .HI_LVL  (HI_LVL),
        .LO_LVL  (LO_LVL)
    ) u_sym (
        .clk       (clk),
        .reset     (reset),
        .load      (sym_load),
        .stop      (sym_stop),
        .data      (sym_data),
        .mode      (sym_mode),
        .tx_out    (o_tx_out),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_tx_sfd  <= 1'b0;
            o_tx_ind  <= 1'b0;
            o_rd_addr <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            loop_q    <= 1'b0;
        end else begin
            o_tx_ind <= 1'b0;
            if (enter_gap) begin
                state    <= S_GAP;
                o_tx_sfd <= 1'b0;
                gap_cnt  <= '0;
                o_tx_ind <= (GAP_CYC == 1);
            end else begin
                case (state)
                    S_IDLE: if (i_start) begin
                        state    <= S_PRE;
                        o_busy   <= 1'b1;
                        mode_q   <= i_mode;
                        len_q    <= len_in;
                        loop_q   <= i_loop;
                        byte_cnt <= '0;
                    end
                    S_PRE: if (byte_done) begin
                        if (pre_last) state <= S_SFD;
                        else          byte_cnt <= byte_cnt + LEN_W'(1);
                    end
                    S_SFD: if (byte_done) begin
                        state     <= S_LEN;
                        o_tx_sfd  <= 1'b1;
                        o_rd_addr <= '0;
                    end
                    S_LEN: if (byte_done) begin
                        state    <= S_PAY;
                        byte_cnt <= '0;
                        if (addr_more) o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    end
                    S_PAY: if (byte_done) begin
                        byte_cnt <= byte_cnt + LEN_W'(1);
                        if (addr_more) o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    end
                    S_GAP: begin
                        if (gap_last) begin
                            if (restart) begin
                                state    <= S_PRE;
                                mode_q   <= i_mode;
                                len_q    <= len_in;
                                loop_q   <= i_loop;
                                byte_cnt <= '0;
                            end else begin
                                state  <= S_IDLE;
                                o_busy <= 1'b0;
                            end
                        end else begin
                            gap_cnt  <= gap_cnt + GAP_W'(1);
                            o_tx_ind <= ((gap_cnt + GAP_W'(1)) == GAP_W'(GAP_CYC - 1));
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vlc_tx_frame_gen.sv
// Bench for vlc_tx_frame_gen: expected per-clock DAC/flag stream is expanded from the
// frame contents into a queue and compared cycle by cycle on the falling edge.
module tb_vlc_tx_frame_gen;

    localparam int WIDTH     = 10;
    localparam int CLK_DIV   = 4;
    localparam int PRE_BYTES = 4;
    localparam int ADDR_W    = 6;
    localparam int GAP_CYC   = 1000;
    localparam int HI_LVL    = 1023;
    localparam int LO_LVL    = 0;
    localparam int MAX_LEN   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_start = 1'b0;
    logic              i_loop = 1'b0;
    logic              i_mode = 1'b0;
    logic [ADDR_W:0]   i_len = '0;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        i_rd_data;
    logic [WIDTH-1:0]  o_tx_out;
    logic              o_clk;
    logic              o_tx_sfd;
    logic              o_tx_ind;
    logic              o_busy;

    vlc_tx_frame_gen #(
        .WIDTH(WIDTH), .CLK_DIV(CLK_DIV), .PRE_BYTES(PRE_BYTES), .ADDR_W(ADDR_W),
        .GAP_CYC(GAP_CYC), .HI_LVL(HI_LVL), .LO_LVL(LO_LVL)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_loop(i_loop), .i_mode(i_mode),
        .i_len(i_len), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_tx_out(o_tx_out),
        .o_clk(o_clk), .o_tx_sfd(o_tx_sfd), .o_tx_ind(o_tx_ind), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [MAX_LEN];
    always @(posedge clk) i_rd_data <= mem[o_rd_addr];

    typedef struct packed {
        logic [WIDTH-1:0] tx;
        logic             sfd;
        logic             ind;
        logic             busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   check_idle = 1'b0;
    int   sfd_cnt = 0;
    int   ind_cnt = 0;
    int   max_addr = 0;
    logic [7:0] len_dec = '0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Stream checker plus monitors for SFD width, LEN-byte decode, address span and done pulses.
    initial begin
        obs_t cur;
        obs_t e;
        obs_t idle_obs;
        idle_obs = '{tx: WIDTH'(LO_LVL), sfd: 1'b0, ind: 1'b0, busy: 1'b0};
        forever begin
            @(negedge clk);
            cur = {o_tx_out, o_tx_sfd, o_tx_ind, o_busy};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL stream @%0t: got tx=%0d sfd=%b ind=%b busy=%b, expected tx=%0d sfd=%b ind=%b busy=%b",
                             $time, cur.tx, cur.sfd, cur.ind, cur.busy, e.tx, e.sfd, e.ind, e.busy);
                end
            end else if (check_idle) begin
                n_checks++;
                if (cur !== idle_obs) begin
                    n_fail++;
                    $display("FAIL idle @%0t: got tx=%0d sfd=%b ind=%b busy=%b, expected tx=%0d sfd=0 ind=0 busy=0",
                             $time, cur.tx, cur.sfd, cur.ind, cur.busy, LO_LVL);
                end
            end
            if (o_tx_sfd === 1'b1) begin
                if (sfd_cnt < 64 && (sfd_cnt % 8) == 1) len_dec[sfd_cnt / 8] = (o_tx_out == WIDTH'(HI_LVL));
                if (int'(o_rd_addr) > max_addr) max_addr = int'(o_rd_addr);
                sfd_cnt++;
            end
            if (o_tx_ind === 1'b1) ind_cnt++;
        end
    end

    task automatic push_frame(input logic mode, input int len_req);
        int         len;
        logic [7:0] bytes[$];
        obs_t       e;
        len = (len_req > MAX_LEN) ? MAX_LEN : len_req;
        for (int k = 0; k < PRE_BYTES; k++) bytes.push_back(8'hAA);
        bytes.push_back(8'hA7);
        bytes.push_back(8'(len));
        for (int j = 0; j < len; j++) bytes.push_back(mem[j]);
        for (int k = 0; k < bytes.size(); k++) begin
            for (int i = 0; i < 8; i++) begin
                for (int h = 0; h < 2; h++) begin
                    logic c;
                    c = bytes[k][i];
                    if (mode && h == 1) c = ~c;
                    e.tx   = c ? WIDTH'(HI_LVL) : WIDTH'(LO_LVL);
                    e.sfd  = (k > PRE_BYTES);
                    e.ind  = 1'b0;
                    e.busy = 1'b1;
                    repeat (CLK_DIV) exp_q.push_back(e);
                end
            end
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            e.tx   = WIDTH'(LO_LVL);
            e.sfd  = 1'b0;
            e.ind  = (g == GAP_CYC - 1);
            e.busy = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic mode, input int len);
        @(negedge clk);
        #1;
        i_mode  = mode;
        i_len   = (ADDR_W+1)'(len);
        i_start = 1'b1;
        push_frame(mode, len);
        @(negedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left after %0d clk, expected 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic clear_mon();
        sfd_cnt  = 0;
        ind_cnt  = 0;
        max_addr = 0;
        len_dec  = '0;
    endtask

    task automatic fill_mem(input logic [7:0] b0, input logic [7:0] b1);
        for (int j = 0; j < MAX_LEN; j++) mem[j] = 8'(j * 37 + 5);
        mem[0] = b0;
        mem[1] = b1;
    endtask

    typedef struct {
        logic       mode;
        int         len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_len_byte;
        int         exp_sfd;
        int         exp_max_addr;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   n;
        vecs[0] = '{mode: 1'b0, len: 2,   b0: 8'h01, b1: 8'h80, exp_len_byte: 8'h02, exp_sfd: 192,  exp_max_addr: 1};
        vecs[1] = '{mode: 1'b1, len: 1,   b0: 8'h03, b1: 8'hFF, exp_len_byte: 8'h01, exp_sfd: 128,  exp_max_addr: 0};
        vecs[2] = '{mode: 1'b0, len: 0,   b0: 8'h5A, b1: 8'h5A, exp_len_byte: 8'h00, exp_sfd: 64,   exp_max_addr: 0};
        vecs[3] = '{mode: 1'b1, len: 100, b0: 8'hC3, b1: 8'h3C, exp_len_byte: 8'h40, exp_sfd: 4160, exp_max_addr: 63};
        vecs[4] = '{mode: 1'b0, len: 5,   b0: 8'hFF, b1: 8'h00, exp_len_byte: 8'h05, exp_sfd: 384,  exp_max_addr: 4};
        fill_mem(8'h00, 8'h00);

        repeat (3) @(negedge clk);
        check("reset_tx_out", o_tx_out, LO_LVL);
        check("reset_busy", o_busy, 0);
        check("reset_sfd", o_tx_sfd, 0);
        check("reset_ind", o_tx_ind, 0);
        check("reset_rd_addr", o_rd_addr, 0);
        check("o_clk_inverted", o_clk, 1);
        #1;
        reset = 1'b0;
        check_idle = 1'b1;
        repeat (50) @(negedge clk);
        check("idle50_tx_out", o_tx_out, LO_LVL);
        check("idle50_busy", o_busy, 0);

        for (int v = 0; v < 5; v++) begin
            fill_mem(vecs[v].b0, vecs[v].b1);
            clear_mon();
            start_frame(vecs[v].mode, vecs[v].len);
            wait_drain(8000);
            repeat (5) @(negedge clk);
            check($sformatf("v%0d_sfd_cycles", v), sfd_cnt, vecs[v].exp_sfd);
            check($sformatf("v%0d_len_byte", v), len_dec, vecs[v].exp_len_byte);
            check($sformatf("v%0d_max_rd_addr", v), max_addr, vecs[v].exp_max_addr);
            check($sformatf("v%0d_done_pulses", v), ind_cnt, 1);
        end

        // Continuous mode: three frames, a stray start pulse, then i_loop dropped in frame 3.
        fill_mem(8'h96, 8'h69);
        clear_mon();
        i_loop = 1'b1;
        start_frame(1'b0, 3);
        push_frame(1'b0, 3);
        push_frame(1'b0, 3);
        repeat (200) @(negedge clk);
        #1;
        i_start = 1'b1;
        @(negedge clk);
        #1;
        i_start = 1'b0;
        n = 0;
        while (exp_q.size() > 1400 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        #1;
        i_loop = 1'b0;
        wait_drain(3000);
        repeat (20) @(negedge clk);
        check("loop_done_pulses", ind_cnt, 3);
        check("loop_sfd_cycles", sfd_cnt, 768);

        // Reset in the middle of payload byte 1 drops the frame.
        fill_mem(8'hE1, 8'h1E);
        clear_mon();
        start_frame(1'b1, 3);
        n = 0;
        while (exp_q.size() > 1100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reset_point_in_pay1", o_tx_sfd, 1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_tx_out", o_tx_out, LO_LVL);
        check("midrst_sfd", o_tx_sfd, 0);
        check("midrst_busy", o_busy, 0);
        #1;
        reset = 1'b0;
        ind_cnt = 0;
        repeat (1100) @(negedge clk);
        check("midrst_no_done", ind_cnt, 0);
        clear_mon();
        start_frame(1'b0, 2);
        wait_drain(3000);
        repeat (5) @(negedge clk);
        check("post_rst_done", ind_cnt, 1);
        check("post_rst_len_byte", len_dec, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time bound, expected completion");
        $fatal(1, "timeout");
    end

endmodule
